mips_bus_access_unit: RTL

//  Load/store access unit placed between the multi-cycle MIPS core and the Avalon-style memory bus.

---
 rtl/mips_bus_access_unit_if.sv | 46 ++++
 rtl/mips_bus_access_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_access_unit_if.sv
// Groups the core request/response and Avalon-style bus signals of mips_bus_access_unit into one bundle.
// Ports, core side: req_valid/req_ready/req_write/req_size/req_signed/req_addr/req_wdata in; rsp_valid/rsp_err/rsp_data/busy out.
// Ports, bus side: address/read/write/byteenable/writedata out; waitrequest/readdata in.
// modport master: the access unit. It masters the memory bus and answers the core.
// modport slave:  the environment. The core issues requests and the memory fabric stalls or returns data.
interface mips_bus_access_unit_if #(
  parameter int ADDR_W = 32
);
  // core request
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  // core response
  logic              rsp_valid;
  logic              rsp_err;
  logic [31:0]       rsp_data;
  logic              busy;
  // memory bus
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic              waitrequest;
  logic [31:0]       readdata;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_err, rsp_data, busy,
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_err, rsp_data, busy,
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_bus_access_unit.sv
// Load/store access unit between a multi-cycle MIPS core and an Avalon-style memory bus.
// Latency: request accepted at cycle N, read/write at N+1, rsp_valid at N+2; each waitrequest cycle adds one.
// Backpressure: one access at a time, req_ready only in IDLE; the bus stalls via waitrequest, with an optional timeout abort.
// Ports: clk, reset (synchronous, active-low), bus (mips_bus_access_unit_if.master: core request/response + memory bus).
module mips_bus_access_unit #(
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = 0,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_bus_access_unit_if.master bus
);

  // The counter only has to reach TIMEOUT. Because it then leaves BUS, it never wraps.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_ERR  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched request and bus-phase state
  logic              wr_q;
  logic              signed_q;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-3:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  // Request decode
  logic              accept;
  logic              req_bad;
  logic [1:0]        req_lane;
  logic [3:0]        req_be;
  logic [31:0]       req_wd;

  // Bus-phase helpers
  logic              timed_out;
  logic [31:0]       lane_data;
  logic [31:0]       load_ext;

  assign accept = (state == S_IDLE) && bus.req_valid && reset;

  // A timeout is reached only after TIMEOUT stalled cycles with the strobe high.
  // In that cycle the strobe is already dropped, so no transfer can complete.
  assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_VAL);

  // Lane, byteenable and replicated write data for the incoming request.
  // For big-endian mode, the lane is mirrored. A half can only start at byte 0 or 2,
  // so (2 - addr) selects the upper or lower pair. Misaligned halves are trapped anyway.
  always_comb begin
    req_lane = 2'b00;
    req_be   = 4'b1111;
    req_wd   = bus.req_wdata;
    req_bad  = 1'b0;
    case (bus.req_size)
      2'b00: begin
        req_lane = BIG_ENDIAN ? (2'd3 - bus.req_addr[1:0]) : bus.req_addr[1:0];
        req_be   = 4'b0001 << req_lane;
        req_wd   = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        req_lane = BIG_ENDIAN ? (2'd2 - bus.req_addr[1:0]) : bus.req_addr[1:0];
        req_be   = 4'b0011 << req_lane;
        req_wd   = {2{bus.req_wdata[15:0]}};
        req_bad  = bus.req_addr[0];
      end
      2'b10: begin
        req_bad  = (bus.req_addr[1:0] != 2'b00);
      end
      default: begin
        req_bad  = 1'b1;
      end
    endcase
  end

  // Load extraction.
  // Words always use lane 0, so the shifted value is readdata unchanged.
  always_comb begin
    lane_data = bus.readdata >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & lane_data[7]}}, lane_data[7:0]};
      2'b01:   load_ext = {{16{signed_q & lane_data[15]}}, lane_data[15:0]};
      default: load_ext = lane_data;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and handshake/strobe outputs
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      S_IDLE: begin
        bus.busy      = 1'b0;
        bus.req_ready = reset;
        if (accept) begin
          state_nxt = req_bad ? S_ERR : S_BUS;
        end
      end
      S_BUS: begin
        if (timed_out) begin
          state_nxt = S_RESP;
        end else begin
          bus.read  = ~wr_q;
          bus.write = wr_q;
          if (!bus.waitrequest) begin
            state_nxt = S_RESP;
          end
        end
      end
      S_ERR: begin
        state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_q;
        state_nxt     = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Request latch, read capture, error flag and stall counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      lane_q   <= 2'b00;
      addr_q   <= '0;
      be_q     <= 4'b0000;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        wr_q     <= bus.req_write;
        signed_q <= bus.req_signed;
        size_q   <= bus.req_size;
        lane_q   <= req_lane;
        addr_q   <= bus.req_addr[ADDR_W-1:2];
        be_q     <= req_be;
        wdata_q  <= req_wd;
        rdata_q  <= 32'h0;
        err_q    <= req_bad;
        cnt_q    <= '0;
      end
      if (state == S_BUS) begin
        if (timed_out) begin
          err_q <= 1'b1;
        end else if (bus.waitrequest) begin
          if (TIMEOUT != 0) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end else if (!wr_q) begin
          rdata_q <= load_ext;
        end
      end
      if (state == S_RESP) begin
        cnt_q <= '0;
      end
    end
  end

  // Bus address, lanes and data come from registers, so they stay stable for the whole stall.
  assign bus.address    = {addr_q, 2'b00};
  assign bus.byteenable = be_q;
  assign bus.writedata  = wdata_q;
  assign bus.rsp_data   = rdata_q;

endmodule
